// File: rtl/gigatron_core_x.sv
// Gigatron-ISA 8-bit core with memory banking, wait-state handshake and a
// debug halt/single-step controller. One instruction per non-stalled cycle.
module gigatron_core_x #(
    parameter int unsigned BANK_BITS = 2,
    parameter logic [15:0] RESET_PC  = 16'h0000
) (
    input  logic                    clock,
    input  logic                    rst_n,
    output logic [15:0]             pc,
    input  logic [15:0]             rom_i,
    output logic [15+BANK_BITS-1:0] addr_r,
    input  logic [7:0]              data_i,
    output logic [15+BANK_BITS-1:0] addr_w,
    output logic [7:0]              data_o,
    output logic                    we,
    input  logic                    mem_ready,
    input  logic [7:0]              inreg,
    output logic [7:0]              out,
    output logic [7:0]              outx,
    output logic [7:0]              ctrl,
    output logic [BANK_BITS-1:0]    bank,
    input  logic                    dbg_halt,
    input  logic                    dbg_step,
    output logic                    halted,
    output logic                    stall
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    state_t         state;
    logic [15:0]    ir;
    logic [7:0]     ac;
    logic [7:0]     x;
    logic [7:0]     y;

    logic [2:0]     op;
    logic [2:0]     mode;
    logic [1:0]     bus;
    logic [7:0]     d;
    logic [15:0]    ea;
    logic [BANK_BITS-1:0] hi;
    logic [7:0]     bval;
    logic [7:0]     alu;
    logic           is_store;
    logic           need_read;
    logic           exec;
    logic           cond;
    logic           taken;
    logic [15:0]    pc_next;

    // Decode, operand select, ALU, branch resolution and stall detection
    always_comb begin
        op        = ir[15:13];
        mode      = ir[12:10];
        bus       = ir[9:8];
        d         = ir[7:0];
        ea        = {8'h00, d};
        hi        = '0;
        bval      = d;
        alu       = d;
        cond      = 1'b0;
        taken     = 1'b0;
        is_store  = (op == 3'd6);
        need_read = (bus == 2'd1) && !is_store;

        if (op != 3'd7) begin
            case (mode)
                3'd1:       ea = {8'h00, x};
                3'd2:       ea = {y, d};
                3'd3, 3'd7: ea = {y, x};
                default:    ea = {8'h00, d};
            endcase
        end
        if (ea[15]) hi = bank;
        addr_r = {hi, ea[14:0]};

        case (bus)
            2'd0:    bval = d;
            2'd1:    bval = data_i;
            2'd2:    bval = ac;
            default: bval = inreg;
        endcase

        case (op)
            3'd1:    alu = ac & bval;
            3'd2:    alu = ac | bval;
            3'd3:    alu = ac ^ bval;
            3'd4:    alu = ac + bval;
            3'd5:    alu = ac - bval;
            default: alu = bval;
        endcase

        // Conditions compare ac as a signed value against zero
        case (mode)
            3'd1:    cond = !ac[7] && (ac != 8'h00);
            3'd2:    cond = ac[7];
            3'd3:    cond = (ac != 8'h00);
            3'd4:    cond = (ac == 8'h00);
            3'd5:    cond = !ac[7];
            3'd6:    cond = ac[7] || (ac == 8'h00);
            default: cond = 1'b1;
        endcase
        taken = (op == 3'd7) && cond;

        pc_next = pc + 16'd1;
        if (taken) pc_next = {(mode == 3'd0) ? y : pc[15:8], bval};

        stall = (need_read || we) && !mem_ready;
        exec  = (state != ST_HALT) && !stall;
    end

    assign halted = (state == ST_HALT);

    // Architectural state, write port and debug FSM
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state  <= ST_RUN;
            pc     <= RESET_PC;
            ir     <= 16'h0200;
            ac     <= 8'h00;
            x      <= 8'h00;
            y      <= 8'h00;
            out    <= 8'h00;
            outx   <= 8'h00;
            ctrl   <= 8'h00;
            bank   <= '0;
            we     <= 1'b0;
            addr_w <= '0;
            data_o <= 8'h00;
        end else begin
            if (we && mem_ready) we <= 1'b0;

            case (state)
                ST_RUN:  if (exec && dbg_halt) state <= ST_HALT;
                ST_HALT: if (dbg_step) state <= ST_STEP;
                ST_STEP: if (exec) state <= dbg_halt ? ST_HALT : ST_RUN;
                default: state <= ST_RUN;
            endcase

            if (exec) begin
                pc <= pc_next;
                ir <= rom_i;
                if (op <= 3'd5) begin
                    case (mode)
                        3'd4: x <= alu;
                        3'd5: y <= alu;
                        3'd6, 3'd7: begin
                            out <= alu;
                            if (!out[6] && alu[6]) outx <= ac;
                            if (mode == 3'd7 && bus == 2'd1) x <= x + 8'd1;
                        end
                        default: ac <= alu;
                    endcase
                end else if (is_store) begin
                    if (bus != 2'd1) begin
                        we     <= 1'b1;
                        addr_w <= addr_r;
                        data_o <= bval;
                        case (mode)
                            3'd4:    x <= bval;
                            3'd5:    y <= bval;
                            3'd7:    x <= x + 8'd1;
                            default: ;
                        endcase
                    end else if (!d[1]) begin
                        ctrl <= d;
                    end else begin
                        bank <= ac[BANK_BITS-1:0];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_gigatron_core_x.sv
// Directed bench for gigatron_core_x: vector table for ALU/store/banking,
// plus hand sequences for branches, wait states, backpressure and debug.
module tb_gigatron_core_x;

    logic        clock = 1'b0;
    logic        rst_n;
    logic [15:0] pc;
    logic [15:0] rom_i;
    logic [16:0] addr_r;
    logic [7:0]  data_i;
    logic [16:0] addr_w;
    logic [7:0]  data_o;
    logic        we;
    logic        mem_ready;
    logic [7:0]  inreg;
    logic [7:0]  out;
    logic [7:0]  outx;
    logic [7:0]  ctrl;
    logic [1:0]  bank;
    logic        dbg_halt;
    logic        dbg_step;
    logic        halted;
    logic        stall;

    localparam logic [15:0] NOP = 16'h0200;

    logic        use_prog;
    logic [15:0] rom_drv;
    logic [15:0] prog [0:511];
    int          nvec = 0;
    int          nmis = 0;
    int          wr_cnt = 0;
    logic [16:0] wr_addr [0:7];

    gigatron_core_x #(.BANK_BITS(2), .RESET_PC(16'h0100)) dut (
        .clock(clock), .rst_n(rst_n), .pc(pc), .rom_i(rom_i),
        .addr_r(addr_r), .data_i(data_i), .addr_w(addr_w), .data_o(data_o),
        .we(we), .mem_ready(mem_ready), .inreg(inreg), .out(out),
        .outx(outx), .ctrl(ctrl), .bank(bank), .dbg_halt(dbg_halt),
        .dbg_step(dbg_step), .halted(halted), .stall(stall)
    );

    always #5 clock = ~clock;

    always_comb rom_i = use_prog ? prog[pc[8:0]] : rom_drv;

    always @(posedge clock) begin
        if (rst_n && we && mem_ready) begin
            if (wr_cnt < 8) wr_addr[wr_cnt] = addr_w;
            wr_cnt = wr_cnt + 1;
        end
    end

    typedef struct {
        logic [15:0] ins;
        logic [7:0]  din;
        logic [16:0] ar;
        logic [7:0]  o;
        logic [7:0]  ox;
        logic [7:0]  c;
        logic [1:0]  bk;
        logic        w;
        logic [16:0] aw;
        logic [7:0]  dout;
    } vec_t;

    vec_t vt [0:22];

    function automatic logic [15:0] enc(input int op, input int mode, input int bus,
                                        input logic [7:0] d);
        return {3'(op), 3'(mode), 2'(bus), d};
    endfunction

    function automatic vec_t mkv(input logic [15:0] ins, input logic [7:0] din,
                                 input logic [16:0] ar, input logic [7:0] o,
                                 input logic [7:0] ox, input logic [7:0] c,
                                 input logic [1:0] bk, input logic w,
                                 input logic [16:0] aw, input logic [7:0] dout);
        vec_t v;
        v.ins = ins; v.din = din; v.ar = ar; v.o = o; v.ox = ox;
        v.c = c; v.bk = bk; v.w = w; v.aw = aw; v.dout = dout;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; mem_ready = 1'b1; dbg_halt = 1'b0; dbg_step = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 512; i++) prog[i] = NOP;
    endtask

    initial begin
        inreg = 8'h99; data_i = 8'h00; rom_drv = NOP; use_prog = 1'b0;
        clear_prog();

        vt[0]  = mkv(enc(0,0,0,8'h7F), 8'h00, 17'h0007F, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 17'h00000, 8'h00);
        vt[1]  = mkv(enc(4,0,0,8'h01), 8'h00, 17'h00001, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 17'h00000, 8'h00);
        vt[2]  = mkv(enc(6,0,2,8'h20), 8'h00, 17'h00020, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1, 17'h00020, 8'h80);
        vt[3]  = mkv(enc(0,0,0,8'h03), 8'h00, 17'h00003, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 17'h00020, 8'h80);
        vt[4]  = mkv(enc(6,0,1,8'h02), 8'h00, 17'h00002, 8'h00, 8'h00, 8'h00, 2'd3, 1'b0, 17'h00020, 8'h80);
        vt[5]  = mkv(enc(0,5,0,8'h80), 8'h00, 17'h00080, 8'h00, 8'h00, 8'h00, 2'd3, 1'b0, 17'h00020, 8'h80);
        vt[6]  = mkv(enc(0,4,0,8'h05), 8'h00, 17'h00005, 8'h00, 8'h00, 8'h00, 2'd3, 1'b0, 17'h00020, 8'h80);
        vt[7]  = mkv(enc(0,3,1,8'h00), 8'h5A, 17'h18005, 8'h00, 8'h00, 8'h00, 2'd3, 1'b0, 17'h00020, 8'h80);
        vt[8]  = mkv(enc(6,0,2,8'h05), 8'h00, 17'h00005, 8'h00, 8'h00, 8'h00, 2'd3, 1'b1, 17'h00005, 8'h5A);
        vt[9]  = mkv(enc(0,6,0,8'h40), 8'h00, 17'h00040, 8'h40, 8'h5A, 8'h00, 2'd3, 1'b0, 17'h00005, 8'h5A);
        vt[10] = mkv(enc(1,0,0,8'h0F), 8'h00, 17'h0000F, 8'h40, 8'h5A, 8'h00, 2'd3, 1'b0, 17'h00005, 8'h5A);
        vt[11] = mkv(enc(2,0,0,8'h30), 8'h00, 17'h00030, 8'h40, 8'h5A, 8'h00, 2'd3, 1'b0, 17'h00005, 8'h5A);
        vt[12] = mkv(enc(3,0,0,8'hFF), 8'h00, 17'h000FF, 8'h40, 8'h5A, 8'h00, 2'd3, 1'b0, 17'h00005, 8'h5A);
        vt[13] = mkv(enc(5,6,0,8'h06), 8'h00, 17'h00006, 8'hBF, 8'h5A, 8'h00, 2'd3, 1'b0, 17'h00005, 8'h5A);
        vt[14] = mkv(enc(0,6,0,8'h00), 8'h00, 17'h00000, 8'h00, 8'h5A, 8'h00, 2'd3, 1'b0, 17'h00005, 8'h5A);
        vt[15] = mkv(enc(0,6,2,8'h00), 8'h00, 17'h00000, 8'hC5, 8'hC5, 8'h00, 2'd3, 1'b0, 17'h00005, 8'h5A);
        vt[16] = mkv(enc(6,0,1,8'h7C), 8'h00, 17'h0007C, 8'hC5, 8'hC5, 8'h7C, 2'd3, 1'b0, 17'h00005, 8'h5A);
        vt[17] = mkv(enc(6,7,3,8'h00), 8'h00, 17'h18005, 8'hC5, 8'hC5, 8'h7C, 2'd3, 1'b1, 17'h18005, 8'h99);
        vt[18] = mkv(enc(0,1,1,8'h00), 8'h11, 17'h00006, 8'hC5, 8'hC5, 8'h7C, 2'd3, 1'b0, 17'h18005, 8'h99);
        vt[19] = mkv(enc(4,0,1,8'h10), 8'h22, 17'h00010, 8'hC5, 8'hC5, 8'h7C, 2'd3, 1'b0, 17'h18005, 8'h99);
        vt[20] = mkv(enc(6,2,2,8'h21), 8'h00, 17'h18021, 8'hC5, 8'hC5, 8'h7C, 2'd3, 1'b1, 17'h18021, 8'h33);
        vt[21] = mkv(enc(0,7,1,8'h00), 8'h44, 17'h18006, 8'h44, 8'hC5, 8'h7C, 2'd3, 1'b0, 17'h18021, 8'h33);
        vt[22] = mkv(enc(6,1,2,8'h00), 8'h00, 17'h00007, 8'h44, 8'hC5, 8'h7C, 2'd3, 1'b1, 17'h00007, 8'h33);

        // Reset values and the first fetch addresses
        do_reset();
        check("reset_pc", pc, 16'h0100);
        check("reset_outs", {out, outx, ctrl, bank, we, addr_w, data_o, halted, stall}, 64'h0);
        tick(); check("pc_after_release_1", pc, 16'h0101);
        tick(); check("pc_after_release_2", pc, 16'h0102);

        // Vector table: each instruction followed by a NOP, observed after it executes
        for (int i = 0; i < 23; i++) begin
            rom_drv = vt[i].ins;
            tick();
            data_i  = vt[i].din;
            rom_drv = NOP;
            #1;
            check($sformatf("vec%0d_addr_r", i), addr_r, vt[i].ar);
            tick();
            check($sformatf("vec%0d_state", i),
                  {out, outx, ctrl, bank, we, addr_w, data_o},
                  {vt[i].o, vt[i].ox, vt[i].c, vt[i].bk, vt[i].w, vt[i].aw, vt[i].dout});
        end

        // Branches: BGT on negative ac not taken, BLT taken after one delay slot
        use_prog = 1'b1;
        clear_prog();
        prog[9'h100] = enc(0,0,0,8'h7F);
        prog[9'h101] = enc(4,0,0,8'h01);
        prog[9'h102] = enc(7,1,0,8'h50);
        prog[9'h104] = enc(7,2,0,8'h60);
        prog[9'h105] = enc(0,6,0,8'h11);
        prog[9'h160] = enc(0,6,0,8'h22);
        do_reset();
        repeat (4) tick();
        check("bgt_not_taken_pc", pc, 16'h0104);
        tick(); tick();
        check("blt_taken_pc", pc, 16'h0160);
        tick(); check("delay_slot_out", out, 8'h11);
        tick(); check("branch_target_out", {out, pc}, {8'h22, 16'h0162});

        // Wait states on a RAM read
        clear_prog();
        prog[9'h100] = enc(0,0,1,8'h10);
        prog[9'h101] = enc(0,6,2,8'h00);
        do_reset();
        tick();
        mem_ready = 1'b0; data_i = 8'hA7;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("wait_stall_%0d", k), {stall, pc}, {1'b1, 16'h0101});
            tick();
        end
        mem_ready = 1'b1;
        #1; check("wait_release_stall", stall, 1'b0);
        tick(); check("wait_release_pc", pc, 16'h0102);
        tick(); check("wait_data_to_out", {out, pc}, {8'hA7, 16'h0103});

        // Store backpressure: one write per store, in order
        clear_prog();
        prog[9'h100] = enc(0,0,0,8'h5C);
        prog[9'h101] = enc(6,0,2,8'h30);
        prog[9'h102] = enc(6,0,2,8'h31);
        do_reset();
        wr_cnt = 0;
        tick(); tick();
        mem_ready = 1'b0;
        tick(); check("bp_first_pending", {we, addr_w, data_o, stall}, {1'b1, 17'h00030, 8'h5C, 1'b1});
        tick(); check("bp_held", {we, addr_w, pc}, {1'b1, 17'h00030, 16'h0103});
        mem_ready = 1'b1;
        tick(); check("bp_second_issued", {we, addr_w, pc, 8'(wr_cnt)}, {1'b1, 17'h00031, 16'h0104, 8'd1});
        mem_ready = 1'b0;
        tick(); check("bp_second_held", {we, stall, pc}, {1'b1, 1'b1, 16'h0104});
        mem_ready = 1'b1;
        tick(); check("bp_drained", {we, pc, 8'(wr_cnt)}, {1'b0, 16'h0105, 8'd2});
        check("bp_write_order", {wr_addr[0], wr_addr[1]}, {17'h00030, 17'h00031});

        // Reset while a write is stalled abandons it
        do_reset();
        tick(); tick();
        mem_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        tick(); check("reset_in_stall", {we, pc, stall}, {1'b0, 16'h0100, 1'b0});
        rst_n = 1'b1; mem_ready = 1'b1;

        // Debug halt and single step
        clear_prog();
        prog[9'h100] = enc(0,0,0,8'h55);
        prog[9'h101] = enc(0,6,0,8'h40);
        do_reset();
        tick();
        dbg_halt = 1'b1;
        tick(); check("halt_entered", {halted, pc}, {1'b1, 16'h0102});
        tick(); check("halt_frozen", {halted, pc}, {1'b1, 16'h0102});
        dbg_step = 1'b1; tick(); dbg_step = 1'b0;
        check("step_state", {halted, pc}, {1'b0, 16'h0102});
        tick(); check("step1_retired", {halted, pc, out, outx}, {1'b1, 16'h0103, 8'h40, 8'h55});
        dbg_step = 1'b1; tick(); dbg_step = 1'b0;
        tick(); check("step2_retired", {halted, pc}, {1'b1, 16'h0104});
        dbg_halt = 1'b0;
        dbg_step = 1'b1; tick(); dbg_step = 1'b0;
        tick(); check("resume_run", {halted, pc}, {1'b0, 16'h0105});
        dbg_step = 1'b1; tick(); dbg_step = 1'b0;
        check("step_ignored_in_run", {halted, pc}, {1'b0, 16'h0106});
        tick(); check("run_continues", pc, 16'h0107);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/gigatron_core_x.md
# gigatron_core_x

Gigatron-ISA-compatible 8-bit CPU core with generic memory banking, a memory wait-state handshake and a debug halt/single-step controller. It is the successor core for the board top level: it executes the same 16-bit instruction stream from ROM and drives the same RAM, IN, OUT/OUTX and ctrl ports. Unlike the single-cycle core, it can stall on slow external memory and be frozen by a debugger.

## Interface
Parameters:
- BANK_BITS, 2: bank register width (1..8); RAM address width is 15+BANK_BITS.
- RESET_PC, 16'h0000: PC value after reset.

Ports:
- clock  in  1  system clock, all state on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- pc  out  16  ROM fetch address.
- rom_i  in  16  instruction at pc, valid the same cycle.
- addr_r  out  15+BANK_BITS  RAM read address, combinational from ir/x/y/bank.
- data_i  in  8  RAM read data, valid when mem_ready=1.
- addr_w  out  15+BANK_BITS  registered RAM write address.
- data_o  out  8  registered RAM write data.
- we  out  1  write strobe; held until accepted.
- mem_ready  in  1  memory accepts the write / read data valid this cycle.
- inreg  in  8  input port (bus=3).
- out  out  8  output port.
- outx  out  8  extended output, latched on out[6] rising.
- ctrl  out  8  control register (SCLK, /SS0-3, B0, B1).
- bank  out  BANK_BITS  current extended bank.
- dbg_halt  in  1  request halt.
- dbg_step  in  1  one-cycle pulse: execute one instruction while halted.
- halted  out  1  core frozen in HALT.
- stall  out  1  current cycle is a wait state.

## Operation
- ir fields: op=ir[15:13], mode=ir[12:10], bus=ir[9:8], d=ir[7:0]. Bus value b: 0 d, 1 RAM, 2 ac, 3 inreg.
- op 0..5 ALU: LD b, AND, OR, XOR, ADD, SUB (8-bit, carry discarded, wraps). Dest by mode: 0-3 ac, 4 x, 5 y, 6-7 out (mode 7 with bus=1 also x<=x+1). Out write: if out[6]=0 and new[6]=1, outx<=ac.
- op 6 store: write b to RAM when bus!=1; mode 4 x<=b, 5 y<=b, 7 x<=x+1. bus=1: ctrl write: if d[1]=0, ctrl<=d; if d[1]=1, bank<=ac[BANK_BITS-1:0], ctrl unchanged.
- op 7 branch: target {base,b}; mode 0 JMP (base=y), 1 GT, 2 LT, 3 NE, 4 EQ, 5 GE, 6 LE (signed ac vs 0), 7 BRA; base=pc[15:8] except mode 0. Branch address (bus=1) reads zero page d.
- Address 16-bit A by mode: op7 or 0,4,5,6 → d; 1 → x; 2 → {y,d}; 3,7 → {y,x}. RAM address = {A[15] ? bank : 0, A[14:0]}.
- FSM RUN/HALT/STEP. RUN: execute each non-stalled cycle; dbg_halt=1 → HALT after the current instruction retires. HALT: no state change; dbg_step=1 → STEP. STEP: retire exactly one instruction (waiting out stalls), then HALT if dbg_halt=1 else RUN. halted=1 only in HALT.

## Timing
- Reset (rst_n=0 at edge): pc=RESET_PC, ir=16'h0200 (NOP), ac=x=y=0, out=outx=ctrl=0, bank=0, we=0, addr_w=data_o=0, state RUN, stall=0.
- One instruction per cycle when not stalled; pipelined fetch gives one branch delay slot (instruction after a branch always executes).
- stall = (bus=1 read needed and mem_ready=0) or (we=1 and mem_ready=0). Stalled/halted cycle: pc, ir, ac, x, y, out, outx, ctrl, bank unchanged.
- we asserted the cycle after a store retires; clears on the first edge with mem_ready=1 unless a new store retires that cycle.
- Store whose write is pending and not accepted: stall holds it; no write is dropped or duplicated.
- rst_n=0 during stall or HALT: reset wins; pending write abandoned (we=0).
- dbg_step while RUN or STEP: ignored.

## Test plan
- Reset: RESET_PC=16'h0100, release rst_n → pc 0100,0101,0102; all outputs 0.
- ALU/branch: LD $7F, ADD $01, BGT → ac=80, branch not taken (signed negative); BLT taken to {pc_hi,d} after one delay slot.
- Banking: ac=3, ST ctrl with d=02 → bank=3, ctrl unchanged; read A=8005 → addr_r=0x18005; A=0005 → 0x00005.
- Wait states: mem_ready low 3 cycles during LD [$10] → stall=1 for 3 cycles, pc frozen, ac gets data_i at release.
- Store backpressure: two back-to-back stores with mem_ready=0 → exactly one write per store, second retires only after first accepted.
- Debug: dbg_halt=1 → halted next cycle; two dbg_step pulses → pc advances by exactly 2; out bit6 rise latches outx=ac.
